// File: rtl/sccb_init_sequencer.sv
// sccb_init_sequencer: walks a {addr, value} init ROM and issues SCCB writes with delays, NACK retry and error report
module sccb_init_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 64,
    parameter int DELAY_UNIT = 1000,
    parameter int MAX_RETRY  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [$clog2(DEPTH)-1:0]   rom_addr,
    input  logic [ADDR_W+DATA_W-1:0]   rom_data,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [ADDR_W+DATA_W-1:0]   cmd_data,
    input  logic                       rsp_valid,
    input  logic                       rsp_err,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [$clog2(DEPTH)-1:0]   err_index
);
    localparam int IW = $clog2(DEPTH);
    localparam int W  = ADDR_W + DATA_W;
    localparam int CW = $clog2((2**DATA_W - 1) * DELAY_UNIT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [ADDR_W-1:0] A_END = '1;
    localparam logic [ADDR_W-1:0] A_DLY = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, WAIT_RSP, DELAY, DONE, ERROR} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   index_q, index_d, err_q, err_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic            adv;
    logic            last;
    logic [ADDR_W-1:0] a_field;
    logic [DATA_W-1:0] v_field;

    assign a_field = rom_data[W-1 -: ADDR_W];
    assign v_field = rom_data[DATA_W-1:0];
    assign last    = index_q == IW'(DEPTH - 1);

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        err_d   = err_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        adv     = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: if (start) begin
                state_d = FETCH;
                index_d = '0;
                retry_d = '0;
                err_d   = '0;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (a_field == A_END) state_d = DONE;
                else if (a_field == A_DLY && v_field != '0) begin
                    cnt_d   = CW'(v_field) * CW'(DELAY_UNIT);
                    state_d = DELAY;
                end else if (a_field == A_DLY) adv = 1'b1;
                else begin
                    data_d  = rom_data;
                    state_d = SEND;
                end
            end
            SEND: state_d = cmd_ready ? WAIT_RSP : SEND;
            WAIT_RSP: if (rsp_valid) begin
                if (!rsp_err) adv = 1'b1;
                else if (retry_q != RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = SEND;
                end else begin
                    err_d   = index_q;
                    state_d = ERROR;
                end
            end
            DELAY: begin
                cnt_d = cnt_q - CW'(1);
                adv   = cnt_q == CW'(1);
            end
            default: state_d = IDLE;
        endcase
        // Table runs off the end without END marker: finish at the last slot
        if (adv) begin
            retry_d = '0;
            state_d = last ? DONE : FETCH;
            index_d = last ? index_q : index_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
            err_q   <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            err_q   <= err_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign rom_addr  = index_q;
    assign cmd_valid = state_q == SEND;
    assign cmd_data  = data_q;
    assign busy      = !(state_q inside {IDLE, DONE, ERROR});
    assign done      = state_q == DONE;
    assign error     = state_q == ERROR;
    assign err_index = err_q;
endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb_sccb_init_sequencer: directed checks of the init sequencer with ROM and SCCB responder models
module tb_sccb_init_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, rdy0 = 1'b1;
    logic [3:0]  rom_addr0, err_index0;
    logic [15:0] rom_data0, cmd_data0;
    logic        cmd_valid0, rv0, re0, busy0, done0, error0;
    logic [15:0] rom0 [16];

    logic        start1 = 1'b0;
    logic [1:0]  rom_addr1, err_index1, max1;
    logic [15:0] rom_data1, cmd_data1;
    logic        cmd_valid1, rv1, busy1, done1, error1;
    logic [15:0] rom1 [4];
    int          n1 = 0;

    int          nsend = 0, nack_lo = 0, nack_hi = 0;
    int          checks = 0, errors = 0;
    logic [15:0] cmds [256];

    sccb_init_sequencer #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .DELAY_UNIT(4), .MAX_RETRY(3)) u0 (
        .clk(clk), .reset(reset), .start(start0), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .cmd_valid(cmd_valid0), .cmd_ready(rdy0), .cmd_data(cmd_data0), .rsp_valid(rv0),
        .rsp_err(re0), .busy(busy0), .done(done0), .error(error0), .err_index(err_index0));

    sccb_init_sequencer #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .DELAY_UNIT(4), .MAX_RETRY(3)) u1 (
        .clk(clk), .reset(reset), .start(start1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .cmd_valid(cmd_valid1), .cmd_ready(1'b1), .cmd_data(cmd_data1), .rsp_valid(rv1),
        .rsp_err(1'b0), .busy(busy1), .done(done1), .error(error1), .err_index(err_index1));

    always @(posedge clk) rom_data0 <= rom0[rom_addr0];
    always @(posedge clk) rom_data1 <= rom1[rom_addr1];

    // Responder: one-cycle response right after each accepted command, NACK inside the send window
    always @(posedge clk) begin
        if (reset) begin
            rv0 <= 1'b0;
            re0 <= 1'b0;
            rv1 <= 1'b0;
        end else begin
            rv0 <= cmd_valid0 & rdy0;
            re0 <= nsend >= nack_lo && nsend < nack_hi;
            rv1 <= cmd_valid1;
            if (cmd_valid0 && rdy0) begin
                cmds[8'(nsend)] <= cmd_data0;
                nsend <= nsend + 1;
            end
            if (cmd_valid1) n1 <= n1 + 1;
        end
        if (rom_addr1 > max1) max1 <= rom_addr1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int i = 0; i < 16; i++) rom0[i] = 16'hFFFF;
        rom0[0] = a;
        rom0[1] = b;
        rom0[2] = c;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done0 || error0) && n < 400) begin
            tick();
            n++;
        end
        chk("finish_in_budget", 32'(n < 400), 1);
    endtask

    task automatic run_valid(output int n);
        pulse0();
        n = 1;
        while (!cmd_valid0 && n < 200) begin
            tick();
            n++;
        end
        chk("delay_cmd_data", cmd_data0, 16'h1201);
        wait_end();
    endtask

    int base, na, nb, k;

    initial begin
        max1 = 2'd0;
        for (int i = 0; i < 4; i++) rom1[i] = 16'h1010 + 16'(i) * 16'h0101;
        load3(16'h1280, 16'h1101, 16'hFFFF);
        tick(); tick(); tick();
        chk("reset_outputs", {cmd_valid0, cmd_data0, rom_addr0, busy0, done0, error0, err_index0}, 0);
        reset = 1'b0;
        tick();

        base = nsend;
        pulse0();
        chk("t1_busy_addr", {busy0, rom_addr0}, {1'b1, 4'd0});
        tick();
        chk("t2_no_valid", cmd_valid0, 0);
        tick();
        chk("t3_valid_data", {cmd_valid0, cmd_data0}, {1'b1, 16'h1280});
        wait_end();
        chk("basic_count", nsend - base, 2);
        chk("basic_cmd0", cmds[8'(base)], 16'h1280);
        chk("basic_cmd1", cmds[8'(base + 1)], 16'h1101);
        chk("basic_flags", {done0, error0, busy0}, 3'b100);

        load3(16'hFE00, 16'h1201, 16'hFFFF);
        run_valid(na);
        load3(16'hFE03, 16'h1201, 16'hFFFF);
        run_valid(nb);
        chk("delay_extra_cycles", nb - na, 12);
        chk("delay_zero_latency", na, 5);

        load3(16'h3E00, 16'h1101, 16'hFFFF);
        base = nsend;
        nack_lo = base;
        nack_hi = base + 2;
        pulse0();
        wait_end();
        chk("retry_count", nsend - base, 4);
        chk("retry_cmds", {cmds[8'(base)], cmds[8'(base + 1)]}, {16'h3E00, 16'h3E00});
        chk("retry_cmd2", cmds[8'(base + 2)], 16'h3E00);
        chk("retry_next", cmds[8'(base + 3)], 16'h1101);
        chk("retry_flags", {done0, error0}, 2'b10);

        for (int i = 0; i < 16; i++) rom0[i] = 16'hFFFF;
        for (int i = 0; i < 5; i++) rom0[i] = 16'h0100 + 16'(i);
        rom0[5] = 16'h0555;
        base = nsend;
        nack_lo = base + 5;
        nack_hi = base + 1000;
        pulse0();
        wait_end();
        chk("err_sends", nsend - base, 9);
        chk("err_last_cmd", cmds[8'(base + 8)], 16'h0555);
        chk("err_flags", {error0, done0, busy0}, 3'b100);
        chk("err_index", err_index0, 5);
        nack_hi = 0;
        pulse0();
        chk("restart_clear", {busy0, error0, rom_addr0}, {2'b10, 4'd0});
        tick(); tick();
        chk("restart_entry0", {cmd_valid0, cmd_data0}, {1'b1, 16'h0100});
        wait_end();
        chk("restart_done", {done0, error0}, 2'b10);

        load3(16'h1280, 16'h1101, 16'hFFFF);
        rdy0 = 1'b0;
        pulse0();
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            chk("hold_stable", {cmd_valid0, cmd_data0}, {1'b1, 16'h1280});
            tick();
        end
        rdy0 = 1'b1;
        wait_end();
        chk("hold_done", done0, 1);

        base = nsend;
        pulse0();
        for (int i = 0; i < 4; i++) tick();
        chk("busy_before_restart", {busy0, rom_addr0}, {1'b1, 4'd1});
        pulse0();
        wait_end();
        chk("start_ignored", nsend - base, 2);
        chk("start_ignored_cmd1", cmds[8'(base + 1)], 16'h1101);

        rdy0 = 1'b0;
        pulse0();
        tick(); tick();
        chk("send_reached", cmd_valid0, 1);
        reset = 1'b1;
        tick();
        chk("reset_in_send", {cmd_valid0, cmd_data0, rom_addr0, busy0, done0, error0, err_index0}, 0);
        reset = 1'b0;
        rdy0 = 1'b1;
        tick();

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        k = 0;
        while (!done1 && k < 200) begin
            tick();
            k++;
        end
        chk("noend_budget", 32'(k < 200), 1);
        chk("noend_count", n1, 4);
        chk("noend_flags", {done1, error1, busy1}, 3'b100);
        chk("noend_max_addr", max1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
